// File: rtl/x_pattern_driver.sv
// UART byte-command pattern driver: static/walk/toggle/count modes on a programmable tick, with pattern readback.
// Loads reach o_data one cycle after the completing byte; readback holds o_tx_data stable until i_tx_ready.
module x_pattern_driver #(
  parameter int p_channels = 25,
  parameter int p_div_w    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic [p_channels-1:0] o_data
);
  localparam int p_bytes = (p_channels + 7) / 8;
  localparam int IDX_W = (p_bytes > 1) ? $clog2(p_bytes) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_bytes - 1);
  localparam logic [p_channels-1:0] ONE = p_channels'(1);
  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [2:0] {S_IDLE, S_MODE, S_PAT, S_DIVL, S_DIVH, S_READ} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [p_channels-1:0] shadow, pat_next, pattern, snap, data_step;
  logic [1:0]            mode;
  logic [p_div_w-1:0]    div, cnt, div_new;
  logic [7:0]            div_lo;
  logic                  tick, last_idx, tx_acc;
  logic                  load_pat, load_mode, load_div, load_any;

  assign last_idx  = (idx == LAST_IDX);
  assign tx_acc    = (state == S_READ) && i_tx_ready;
  assign load_pat  = (state == S_PAT) && i_rx_valid && last_idx;
  assign load_mode = (state == S_MODE) && i_rx_valid;
  assign load_div  = (state == S_DIVH) && i_rx_valid;
  assign load_any  = load_pat || load_mode || load_div;
  assign tick      = (cnt == div);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_M:   state_nxt = S_MODE;
          CMD_P:   state_nxt = S_PAT;
          CMD_D:   state_nxt = S_DIVL;
          CMD_R:   state_nxt = S_READ;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_MODE:  if (i_rx_valid) state_nxt = S_IDLE;
      S_PAT:   if (i_rx_valid && last_idx) state_nxt = S_IDLE;
      S_DIVL:  if (i_rx_valid) state_nxt = S_DIVH;
      S_DIVH:  if (i_rx_valid) state_nxt = S_IDLE;
      S_READ:  if (tx_acc && last_idx) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != S_IDLE);
    o_tx_valid = (state == S_READ);
    o_tx_data  = 8'h00;
    if (state == S_READ) begin
      for (int b = 0; b < p_channels; b++)
        if (IDX_W'(b / 8) == idx) o_tx_data[b % 8] = snap[b];
    end
  end

  // Final pattern: the byte arriving now overlays its lane of the shadow
  always_comb begin
    pat_next = shadow;
    for (int b = 0; b < p_channels; b++)
      if (IDX_W'(b / 8) == idx) pat_next[b] = i_rx_data[b % 8];
  end

  always_comb begin
    div_new = '0;
    for (int b = 0; b < p_div_w && b < 16; b++) begin
      if (b < 8) div_new[b] = div_lo[b % 8];
      else       div_new[b] = i_rx_data[b % 8];
    end
  end

  always_comb begin
    case (mode)
      2'd0:    data_step = o_data;
      2'd1:    data_step = (o_data << 1) | (o_data >> (p_channels - 1));
      2'd2:    data_step = ~o_data;
      default: data_step = o_data + ONE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idx     <= '0;
      shadow  <= '0;
      pattern <= '0;
      snap    <= '0;
      mode    <= 2'd0;
      div     <= '0;
      div_lo  <= 8'h00;
      cnt     <= '0;
      o_data  <= '0;
    end else begin
      if (state == S_IDLE && i_rx_valid && (i_rx_data == CMD_P || i_rx_data == CMD_R))
        idx <= '0;
      else if ((state == S_PAT && i_rx_valid) || tx_acc)
        idx <= idx + 1'b1;

      if (state == S_IDLE && i_rx_valid && i_rx_data == CMD_R) snap <= o_data;
      if (state == S_PAT && i_rx_valid) shadow <= pat_next;
      if (load_pat) pattern <= pat_next;
      if (load_mode) mode <= i_rx_data[1:0];
      if (state == S_DIVL && i_rx_valid) div_lo <= i_rx_data;
      if (load_div) div <= div_new;

      if (load_any || tick) cnt <= '0;
      else                  cnt <= cnt + 1'b1;

      // Any command completion takes priority and swallows a coincident tick
      if (load_pat)       o_data <= pat_next;
      else if (load_mode) o_data <= pattern;
      else if (!load_div && tick) o_data <= data_step;
    end
  end
endmodule

// File: tb/tb_x_pattern_driver.sv
// Randomized bench for x_pattern_driver against an arithmetic reference model of pattern evolution and readback.
module tb_x_pattern_driver;
  localparam int CH = 25;
  localparam longint FULL = 64'd1 << CH;
  localparam int LD_NONE = 0;
  localparam int LD_PAT  = 1;
  localparam int LD_MODE = 2;
  localparam int LD_DIV  = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          i_tx_ready = 1'b0;
  logic          o_tx_valid;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic [CH-1:0] o_data;

  int     n_chk = 0;
  int     n_pass = 0;
  longint exp_data = 0;
  longint pat_m = 0;
  longint div_m = 0;
  longint since = 0;
  int     mode_m = 0;
  int     gap_max = 0;

  x_pattern_driver dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic longint advance(input longint v, input int m);
    case (m)
      1:       return ((v * 2) % FULL) + (v / (FULL / 2));
      2:       return FULL - 1 - v;
      3:       return (v + 1) % FULL;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, expv, $time);
  endtask

  task automatic model_reset();
    exp_data = 0; pat_m = 0; div_m = 0; since = 0; mode_m = 0;
  endtask

  task automatic tick_clk(input logic vld, input logic [7:0] b, input int ld, input longint val);
    i_rx_valid = vld;
    i_rx_data  = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    case (ld)
      LD_PAT:  begin pat_m = val; exp_data = val; since = 0; end
      LD_MODE: begin mode_m = int'(val); exp_data = pat_m; since = 0; end
      LD_DIV:  begin div_m = val; since = 0; end
      default: begin
        if (since == div_m) begin
          exp_data = advance(exp_data, mode_m);
          since = 0;
        end else since++;
      end
    endcase
    chk("o_data", longint'(o_data), exp_data);
  endtask

  task automatic idle(input int n);
    repeat (n) tick_clk(1'b0, 8'h00, LD_NONE, 0);
  endtask

  task automatic gap();
    if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
  endtask

  task automatic send_pat(input logic [CH-1:0] v, input logic [6:0] junk);
    logic [31:0] w;
    w = {junk, v};
    tick_clk(1'b1, 8'h50, LD_NONE, 0);
    chk("busy_pat", longint'(o_busy), 1);
    for (int i = 0; i < 4; i++) begin
      gap();
      tick_clk(1'b1, w[i*8 +: 8], (i == 3) ? LD_PAT : LD_NONE, longint'(v));
    end
    chk("busy_pat_done", longint'(o_busy), 0);
  endtask

  task automatic send_mode(input logic [7:0] b);
    tick_clk(1'b1, 8'h4D, LD_NONE, 0);
    chk("busy_mode", longint'(o_busy), 1);
    gap();
    tick_clk(1'b1, b, LD_MODE, longint'(b[1:0]));
    chk("busy_mode_done", longint'(o_busy), 0);
  endtask

  task automatic send_div(input logic [15:0] d);
    tick_clk(1'b1, 8'h44, LD_NONE, 0);
    gap();
    tick_clk(1'b1, d[7:0], LD_NONE, 0);
    chk("busy_div", longint'(o_busy), 1);
    gap();
    tick_clk(1'b1, d[15:8], LD_DIV, longint'(d));
    chk("busy_div_done", longint'(o_busy), 0);
  endtask

  task automatic read_back(input int stall0);
    logic [31:0] snap;
    int nst;
    snap = 32'(exp_data);
    tick_clk(1'b1, 8'h52, LD_NONE, 0);
    for (int k = 0; k < 4; k++) begin
      nst = (k == 0) ? stall0 : int'($urandom_range(0, 2));
      i_tx_ready = 1'b0;
      for (int s = 0; s < nst; s++) begin
        chk("rd_vld_stall", longint'(o_tx_valid), 1);
        chk("rd_dat_stall", longint'(o_tx_data), longint'(snap[k*8 +: 8]));
        chk("rd_busy", longint'(o_busy), 1);
        tick_clk(s == 1, 8'h4D, LD_NONE, 0);
      end
      i_tx_ready = 1'b1;
      chk("rd_vld", longint'(o_tx_valid), 1);
      chk("rd_dat", longint'(o_tx_data), longint'(snap[k*8 +: 8]));
      tick_clk(1'b0, 8'h00, LD_NONE, 0);
      i_tx_ready = 1'b0;
    end
    chk("rd_vld_end", longint'(o_tx_valid), 0);
    chk("rd_busy_end", longint'(o_busy), 0);
  endtask

  initial begin
    logic [7:0] g;
    int r;
    #13;
    chk("rst_data", longint'(o_data), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_tx_vld", longint'(o_tx_valid), 0);
    chk("rst_tx_dat", longint'(o_tx_data), 0);
    #4 i_rst = 1'b1;

    // walking one, one step per cycle, wrapping from bit 24
    send_pat(25'h0000001, 7'h00);
    send_mode(8'h01);
    send_div(16'h0000);
    idle(30);

    // count wraps all-ones to zero
    send_pat(25'h1FFFFFF, 7'h00);
    send_mode(8'h03);
    chk("t2_loaded", longint'(o_data), 64'h1FFFFFF);
    idle(4);

    // toggle every 4 cycles
    send_pat(25'h0AAAAAA, 7'h00);
    send_mode(8'h02);
    send_div(16'h0003);
    idle(20);

    // readback with an initial 5-cycle stall and a dropped 'M'
    send_pat(25'h1234567, 7'h00);
    send_mode(8'h00);
    chk("t4_pat", longint'(o_data), 64'h1234567);
    read_back(5);
    idle(3);

    // unknown byte ignored, mode byte upper bits ignored
    tick_clk(1'b1, 8'h7A, LD_NONE, 0);
    chk("t5_unknown_busy", longint'(o_busy), 0);
    send_mode(8'hFF);
    idle(12);

    // reset in the middle of a pattern transfer
    tick_clk(1'b1, 8'h50, LD_NONE, 0);
    tick_clk(1'b1, 8'h11, LD_NONE, 0);
    tick_clk(1'b1, 8'h22, LD_NONE, 0);
    #3 i_rst = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_data", longint'(o_data), 0);
    chk("t6_rst_busy", longint'(o_busy), 0);
    #12 i_rst = 1'b1;
    send_pat(25'h1555555, 7'h7F);
    chk("t6_reload", longint'(o_data), 64'h1555555);
    idle(3);

    // randomized command mix with gaps inside commands
    gap_max = 2;
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: send_pat(CH'($urandom), 7'($urandom));
        1: send_mode(8'($urandom));
        2: send_div({8'h00, 8'($urandom_range(0, 6))});
        3: read_back(int'($urandom_range(0, 3)));
        4: begin
          do g = 8'($urandom);
          while (g == 8'h4D || g == 8'h50 || g == 8'h44 || g == 8'h52);
          tick_clk(1'b1, g, LD_NONE, 0);
          chk("junk_busy", longint'(o_busy), 0);
        end
        default: idle(int'($urandom_range(1, 8)));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
